// File: rtl/controle_multiciclo.sv
// Multi-cycle MIPS32 control FSM: sequences fetch/decode/execute/memory/write-back
// and drives the ULA operation code plus every datapath strobe and mux select.
module controle_multiciclo (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero_flag,
    input  logic       mem_pronto,
    output logic [3:0] codigo_controle,
    output logic       pc_escreve,
    output logic       ir_escreve,
    output logic       mem_le,
    output logic       mem_escreve,
    output logic       reg_escreve,
    output logic       iord,
    output logic [1:0] sel_ula_a,
    output logic [2:0] sel_ula_b,
    output logic [1:0] sel_reg_dst,
    output logic [1:0] sel_mem_reg,
    output logic [1:0] sel_pc,
    output logic [3:0] estado,
    output logic       instr_invalida
);

    typedef enum logic [3:0] {
        BUSCA    = 4'd0,
        DECOD    = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        END_MEM  = 4'd4,
        LE_MEM   = 4'd5,
        ESCR_MEM = 4'd6,
        WB_MEM   = 4'd7,
        WB_ALU   = 4'd8,
        DESVIO   = 4'd9,
        SALTO    = 4'd10,
        ERRO     = 4'd11
    } estado_t;

    estado_t estado_atual;
    logic    invalida_q;
    logic    funct_valido;

    // R-type functs the ULA can execute (jr is routed to SALTO in DECOD)
    always_comb begin
        case (funct)
            6'h00, 6'h02, 6'h03, 6'h20, 6'h22, 6'h24,
            6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: funct_valido = 1'b1;
            default:                            funct_valido = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_atual <= BUSCA;
            invalida_q   <= 1'b0;
        end else begin
            case (estado_atual)
                BUSCA:    if (mem_pronto) estado_atual <= DECOD;
                DECOD: begin
                    case (opcode)
                        6'h00:                     estado_atual <= (funct == 6'h08) ? SALTO : EXEC_R;
                        6'h23, 6'h2B:              estado_atual <= END_MEM;
                        6'h04, 6'h05:              estado_atual <= DESVIO;
                        6'h02, 6'h03:              estado_atual <= SALTO;
                        6'h08, 6'h0A, 6'h0B, 6'h0C,
                        6'h0D, 6'h0E, 6'h0F:       estado_atual <= EXEC_I;
                        default: begin
                            estado_atual <= ERRO;
                            invalida_q   <= 1'b1;
                        end
                    endcase
                end
                EXEC_R: begin
                    if (funct_valido) begin
                        estado_atual <= WB_ALU;
                    end else begin
                        estado_atual <= ERRO;
                        invalida_q   <= 1'b1;
                    end
                end
                EXEC_I:   estado_atual <= WB_ALU;
                END_MEM:  estado_atual <= (opcode == 6'h23) ? LE_MEM : ESCR_MEM;
                LE_MEM:   if (mem_pronto) estado_atual <= WB_MEM;
                ESCR_MEM: if (mem_pronto) estado_atual <= BUSCA;
                WB_MEM, WB_ALU, DESVIO, SALTO: estado_atual <= BUSCA;
                ERRO:     estado_atual <= ERRO;
                default:  estado_atual <= ERRO;
            endcase
        end
    end

    // Moore-style decode from the state register; only pc_escreve/ir_escreve
    // look at same-cycle mem_pronto/zero_flag. Everything is forced low in reset.
    always_comb begin
        codigo_controle = 4'b0000;
        pc_escreve      = 1'b0;
        ir_escreve      = 1'b0;
        mem_le          = 1'b0;
        mem_escreve     = 1'b0;
        reg_escreve     = 1'b0;
        iord            = 1'b0;
        sel_ula_a       = 2'b00;
        sel_ula_b       = 3'b000;
        sel_reg_dst     = 2'b00;
        sel_mem_reg     = 2'b00;
        sel_pc          = 2'b00;
        estado          = 4'd0;
        instr_invalida  = 1'b0;
        if (!reset) begin
            estado         = estado_atual;
            instr_invalida = invalida_q;
            case (estado_atual)
                BUSCA: begin
                    mem_le     = 1'b1;
                    sel_ula_b  = 3'b001;
                    ir_escreve = mem_pronto;
                    pc_escreve = mem_pronto;
                end
                DECOD: sel_ula_b = 3'b011;
                EXEC_R: begin
                    sel_ula_a = 2'b01;
                    case (funct)
                        6'h20: codigo_controle = 4'b0000;
                        6'h22: codigo_controle = 4'b0001;
                        6'h24: codigo_controle = 4'b0010;
                        6'h25: codigo_controle = 4'b0011;
                        6'h26: codigo_controle = 4'b0101;
                        6'h27: codigo_controle = 4'b0110;
                        6'h2A: codigo_controle = 4'b0100;
                        6'h2B: codigo_controle = 4'b1010;
                        6'h00: begin codigo_controle = 4'b0111; sel_ula_a = 2'b10; sel_ula_b = 3'b100; end
                        6'h02: begin codigo_controle = 4'b1000; sel_ula_a = 2'b10; sel_ula_b = 3'b100; end
                        6'h03: begin codigo_controle = 4'b1001; sel_ula_a = 2'b10; sel_ula_b = 3'b100; end
                        default: codigo_controle = 4'b0000;
                    endcase
                end
                EXEC_I: begin
                    sel_ula_a = 2'b01;
                    case (opcode)
                        6'h08: begin codigo_controle = 4'b0000; sel_ula_b = 3'b010; end
                        6'h0A: begin codigo_controle = 4'b0100; sel_ula_b = 3'b010; end
                        6'h0B: begin codigo_controle = 4'b1010; sel_ula_b = 3'b010; end
                        6'h0C: begin codigo_controle = 4'b0010; sel_ula_b = 3'b101; end
                        6'h0D: begin codigo_controle = 4'b0011; sel_ula_b = 3'b101; end
                        6'h0E: begin codigo_controle = 4'b0101; sel_ula_b = 3'b101; end
                        6'h0F: begin codigo_controle = 4'b1111; sel_ula_b = 3'b101; end
                        default: codigo_controle = 4'b0000;
                    endcase
                end
                WB_ALU: begin
                    reg_escreve = 1'b1;
                    sel_reg_dst = (opcode == 6'h00) ? 2'b01 : 2'b00;
                end
                END_MEM: begin
                    sel_ula_a = 2'b01;
                    sel_ula_b = 3'b010;
                end
                LE_MEM: begin
                    mem_le = 1'b1;
                    iord   = 1'b1;
                end
                ESCR_MEM: begin
                    mem_escreve = 1'b1;
                    iord        = 1'b1;
                end
                WB_MEM: begin
                    reg_escreve = 1'b1;
                    sel_mem_reg = 2'b01;
                end
                DESVIO: begin
                    sel_ula_a       = 2'b01;
                    codigo_controle = (opcode == 6'h05) ? 4'b1110 : 4'b1100;
                    sel_pc          = 2'b01;
                    pc_escreve      = zero_flag;
                end
                SALTO: begin
                    pc_escreve = zero_flag;
                    if (opcode == 6'h00) begin
                        codigo_controle = 4'b1011;
                        sel_pc          = 2'b11;
                    end else begin
                        codigo_controle = 4'b1101;
                        sel_pc          = 2'b10;
                        if (opcode == 6'h03) begin
                            reg_escreve = 1'b1;
                            sel_reg_dst = 2'b10;
                            sel_mem_reg = 2'b10;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
